// File: rtl/corevx_tlb_assoc.sv
// corevx_tlb_assoc: set-associative TLB (2**WAYS_W ways x 2**ENTRIES_W sets) with resolve, write-update
// and a one-set-per-cycle invalidate-all sweep. Define CORE_TLB_PERF_EN for saturating hit/miss counters.
module corevx_tlb_assoc #(
  parameter int unsigned ENTRIES_W = 4,
  parameter int unsigned WAYS_W    = 2,
  parameter int unsigned VPN_W     = 20,
  parameter int unsigned PPN_W     = 22,
  parameter int unsigned ATAG_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        command,
  output logic              ready,
  input  logic [VPN_W-1:0]  virtual_address,
  output logic              resolve_done,
  output logic              hit,
  output logic [ATAG_W-1:0] accesstag_r,
  output logic [PPN_W-1:0]  phys_r,
  input  logic [VPN_W-1:0]  virtual_address_w,
  input  logic [ATAG_W-1:0] accesstag_w,
  input  logic [PPN_W-1:0]  phys_w
`ifdef CORE_TLB_PERF_EN
  ,
  output logic [31:0]       perf_hits,
  output logic [31:0]       perf_misses
`endif
);

  localparam int unsigned ENTRIES = 1 << ENTRIES_W;
  localparam int unsigned WAYS    = 1 << WAYS_W;
  localparam int unsigned TAG_W   = VPN_W - ENTRIES_W;
  localparam int unsigned PTR_W   = (WAYS_W == 0) ? 1 : WAYS_W;

  typedef enum logic [1:0] {CMD_NONE, CMD_RESOLVE, CMD_WRITE, CMD_INVAL} cmd_t;
  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t               state_q, state_d;
  logic [ENTRIES_W-1:0] idx_q, idx_d;
  logic                 flush_en;
  cmd_t                 cmd;

  logic [WAYS-1:0]   valid_q [ENTRIES];
  logic [TAG_W-1:0]  vtag_q  [ENTRIES][WAYS];
  logic [PPN_W-1:0]  ppn_q   [ENTRIES][WAYS];
  logic [ATAG_W-1:0] atag_q  [ENTRIES][WAYS];
  logic [PTR_W-1:0]  ptr_q   [ENTRIES];

  logic [ENTRIES_W-1:0] r_set, w_set;
  logic [TAG_W-1:0]     r_tag, w_tag;
  logic                 r_hit;
  logic [PTR_W-1:0]     r_way;
  logic                 w_match, w_free, w_bump;
  logic [PTR_W-1:0]     w_match_way, w_free_way, w_way, ptr_inc;
  logic                 do_resolve, do_write, do_inval;

  assign cmd   = cmd_t'(command);
  assign r_set = virtual_address[ENTRIES_W-1:0];
  assign r_tag = virtual_address[VPN_W-1:ENTRIES_W];
  assign w_set = virtual_address_w[ENTRIES_W-1:0];
  assign w_tag = virtual_address_w[VPN_W-1:ENTRIES_W];

  assign do_resolve = ready && (cmd == CMD_RESOLVE);
  assign do_write   = ready && (cmd == CMD_WRITE);
  assign do_inval   = ready && (cmd == CMD_INVAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd == CMD_INVAL) begin
          state_d = S_FLUSH;
          idx_d   = '0;
        end
      end
      S_FLUSH: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == ENTRIES_W'(ENTRIES - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready    = (state_q == S_IDLE);
    flush_en = (state_q == S_FLUSH);
  end

  // Lookup: lowest matching way wins if duplicates ever exist.
  always_comb begin
    r_hit = 1'b0;
    r_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!r_hit && valid_q[r_set][w] && (vtag_q[r_set][w] == r_tag)) begin
        r_hit = 1'b1;
        r_way = PTR_W'(w);
      end
    end
  end

  always_comb begin
    w_match     = 1'b0;
    w_match_way = '0;
    w_free      = 1'b0;
    w_free_way  = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!w_match && valid_q[w_set][w] && (vtag_q[w_set][w] == w_tag)) begin
        w_match     = 1'b1;
        w_match_way = PTR_W'(w);
      end
      if (!w_free && !valid_q[w_set][w]) begin
        w_free     = 1'b1;
        w_free_way = PTR_W'(w);
      end
    end
    if (w_match) begin
      w_way  = w_match_way;
      w_bump = 1'b0;
    end else if (w_free) begin
      w_way  = w_free_way;
      w_bump = 1'b0;
    end else begin
      w_way  = ptr_q[w_set];
      w_bump = 1'b1;
    end
  end

  assign ptr_inc = (WAYS_W == 0) ? '0 : PTR_W'(ptr_q[w_set] + 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < ENTRIES; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else if (flush_en) begin
      valid_q[idx_q] <= '0;
      ptr_q[idx_q]   <= '0;
    end else if (do_write) begin
      valid_q[w_set][w_way] <= accesstag_w[0];
      if (w_bump) ptr_q[w_set] <= ptr_inc;
    end
  end

  // Payload needs no reset: it is only ever observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (do_write) begin
      vtag_q[w_set][w_way] <= w_tag;
      ppn_q[w_set][w_way]  <= phys_w;
      atag_q[w_set][w_way] <= accesstag_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resolve_done <= 1'b0;
      hit          <= 1'b0;
      accesstag_r  <= '0;
      phys_r       <= '0;
    end else begin
      resolve_done <= do_resolve;
      if (do_resolve) begin
        hit         <= r_hit;
        accesstag_r <= r_hit ? atag_q[r_set][r_way] : '0;
        phys_r      <= r_hit ? ppn_q[r_set][r_way] : '0;
      end else if (do_inval) begin
        hit         <= 1'b0;
        accesstag_r <= '0;
        phys_r      <= '0;
      end
    end
  end

`ifdef CORE_TLB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || do_inval) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else if (resolve_done) begin
      if (hit && (perf_hits != '1))     perf_hits   <= perf_hits + 32'd1;
      if (!hit && (perf_misses != '1))  perf_misses <= perf_misses + 32'd1;
    end
  end
`endif

endmodule
